// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: board-side signal bundle for the shift-register sequencer.
// The master side (switch decode) drives the commands and inputs. The slave side
// (the sequencer) drives the register contents, the progress flags and the display.
//
// Handshake: 'start' is a level request. It is sampled only while the sequencer
// is idle. There is no ready wire. busy=1 means commands are being ignored, and
// 'done' pulses for exactly one cycle when the operation completes. A start
// still held after done parks the sequencer until start drops, so a held switch
// never retriggers an operation.
interface shift_sequencer_if #(
    parameter int NBITS = 4
);
    localparam int CW = $clog2(NBITS + 1);

    logic             start;
    logic             selecao;
    logic             entradaSerial;
    logic [NBITS-1:0] entradaParalela;
    logic [NBITS-1:0] dados;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;
    logic [7:0]       SEG;
    logic [2:0]       state_dbg;

    modport master (
        output start, selecao, entradaSerial, entradaParalela,
        input  dados, busy, done, count, SEG, state_dbg
    );

    modport slave (
        input  start, selecao, entradaSerial, entradaParalela,
        output dados, busy, done, count, SEG, state_dbg
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: sequences either a parallel load or an NBITS-step serial
// shift into an internal data register. Each operation starts from a level
// start command. Progress is reported through busy, count and a one-cycle
// done pulse.
// Optional feature: define SHIFT_SEQUENCER_SEG7_EN to drive SEG with a hex
// decode of dados[3:0], with SEG[7] carrying busy. Without it, SEG is tied to
// zero.
module shift_sequencer #(
    parameter int NBITS    = 4,
    parameter int TICK_DIV = 1
) (
    input  logic               clk_2,
    input  logic               reset,
    shift_sequencer_if.slave   bus
);
    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(NBITS);
    localparam logic [CW-1:0] COUNT_LAST = CW'(NBITS - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] dados_q, dados_d;
    logic [CW-1:0]    count_q, count_d;
    logic [TW-1:0]    tick_q,  tick_d;
    logic             busy_w;
    logic             done_w;

    // State register: every piece of state clears at once when reset goes low.
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dados_q <= '0;
            count_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            dados_q <= dados_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic. Commands are only looked at in IDLE, the parallel value
    // only in LOAD, and the serial bit only on a step edge.
    always_comb begin
        state_d = state_q;
        dados_d = dados_q;
        count_d = count_q;
        tick_d  = tick_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.selecao) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_SHIFT;
                        count_d = '0;
                        tick_d  = '0;
                    end
                end
            end
            ST_LOAD: begin
                // The parallel load leaves count at its previous value.
                dados_d = bus.entradaParalela;
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                if (tick_q == TICK_LAST) begin
                    dados_d = {dados_q[NBITS-2:0], bus.entradaSerial};
                    count_d = count_q + CW'(1);
                    tick_d  = '0;
                    // The step that brings count to NBITS ends the operation,
                    // so count can never pass NBITS.
                    if (count_q == COUNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_DONE: begin
                state_d = bus.start ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are decoded from registered state only, so no input
    // reaches an output combinationally.
    always_comb begin
        busy_w = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_DONE);
        done_w = (state_q == ST_DONE);
    end

    assign bus.dados     = dados_q;
    assign bus.count     = count_q;
    assign bus.busy      = busy_w;
    assign bus.done      = done_w;
    assign bus.state_dbg = state_q;

`ifdef SHIFT_SEQUENCER_SEG7_EN
    logic [3:0] nibble;
    logic [6:0] seg_hex;

    assign nibble = 4'(dados_q);

    // Hex digit decode of the low nibble, segment order gfedcba, active high.
    always_comb begin
        seg_hex = 7'h00;
        unique case (nibble)
            4'h0: seg_hex = 7'h3F;
            4'h1: seg_hex = 7'h06;
            4'h2: seg_hex = 7'h5B;
            4'h3: seg_hex = 7'h4F;
            4'h4: seg_hex = 7'h66;
            4'h5: seg_hex = 7'h6D;
            4'h6: seg_hex = 7'h7D;
            4'h7: seg_hex = 7'h07;
            4'h8: seg_hex = 7'h7F;
            4'h9: seg_hex = 7'h6F;
            4'hA: seg_hex = 7'h77;
            4'hB: seg_hex = 7'h7C;
            4'hC: seg_hex = 7'h39;
            4'hD: seg_hex = 7'h5E;
            4'hE: seg_hex = 7'h79;
            4'hF: seg_hex = 7'h71;
            default: seg_hex = 7'h00;
        endcase
    end

    assign bus.SEG = {busy_w, seg_hex};
`else
    assign bus.SEG = 8'h00;
`endif

    // Structural invariants of the sequencer.
    a_count_bounded: assert property (@(posedge clk_2) disable iff (!reset)
        count_q <= COUNT_FULL);
    a_done_one_cycle: assert property (@(posedge clk_2) disable iff (!reset)
        done_w |=> !done_w);
    a_state_legal: assert property (@(posedge clk_2) disable iff (!reset)
        state_q inside {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE, ST_HOLD});

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer. It runs two
// instances, one with TICK_DIV=1 and one with TICK_DIV=3, against a reference
// model built from plain arithmetic. The bench follows the
// SHIFT_SEQUENCER_SEG7_EN define for the expected SEG values.
module tb_shift_sequencer;
    localparam int NBITS = 4;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int TD_B  = 3;
    localparam int VW    = NBITS + CW + 10;

    typedef logic [VW-1:0] vec_t;

    // ---------------- clock / reset ----------------
    logic clk_2 = 1'b0;
    logic reset = 1'b0;
    always #5 clk_2 = ~clk_2;

    shift_sequencer_if #(.NBITS(NBITS)) bus_a ();
    shift_sequencer_if #(.NBITS(NBITS)) bus_b ();

    shift_sequencer #(.NBITS(NBITS), .TICK_DIV(1)) dut_a (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_a)
    );

    shift_sequencer #(.NBITS(NBITS), .TICK_DIV(TD_B)) dut_b (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus_b)
    );

    // ---------------- scoreboard / model state ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [NBITS-1:0] exp_q[$];
    int md_a = 0, mc_a = 0;   // model register value and step count, instance A
    int md_b = 0, mc_b = 0;   // same for instance B

`ifdef SHIFT_SEQUENCER_SEG7_EN
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif

    // Expected output bundle: {dados, count, busy, done, SEG}.
    function automatic vec_t exp_vec(input int d, input int c, input bit b, input bit dn);
        logic [7:0] seg;
`ifdef SHIFT_SEQUENCER_SEG7_EN
        seg = {b, seg_tab[d % 16]};
`else
        seg = 8'h00;
`endif
        return {NBITS'(d), CW'(c), b, dn, seg};
    endfunction

    function automatic vec_t obs_a();
        return {bus_a.dados, bus_a.count, bus_a.busy, bus_a.done, bus_a.SEG};
    endfunction

    function automatic vec_t obs_b();
        return {bus_b.dados, bus_b.count, bus_b.busy, bus_b.done, bus_b.SEG};
    endfunction

    // One serial step: the new bit enters at the bottom, the oldest bit falls off.
    function automatic int step_model(input int d, input int bit_in);
        return (d * 2 + bit_in) % (1 << NBITS);
    endfunction

    // ---------------- driver tasks / scenarios ----------------
    task automatic drive_idle();
        bus_a.start = 0; bus_a.selecao = 0; bus_a.entradaSerial = 0; bus_a.entradaParalela = '0;
        bus_b.start = 0; bus_b.selecao = 0; bus_b.entradaSerial = 0; bus_b.entradaParalela = '0;
    endtask

    task automatic test_reset();
        vec_t e;
        drive_idle();
        reset = 0;
        repeat (2) @(posedge clk_2);
        #1;
        e = exp_vec(0, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL reset_initial: got %h expected %h", obs_a(), e);
        else pass_cnt++;
        @(negedge clk_2) reset = 1;
        // Two serial steps (bits 1, 0), then a reset pulse in the middle of a cycle.
        @(negedge clk_2) begin bus_a.start = 1; bus_a.selecao = 0; end
        @(negedge clk_2) begin bus_a.start = 0; bus_a.entradaSerial = 1; end
        @(negedge clk_2) bus_a.entradaSerial = 0;
        @(posedge clk_2);
        #1;
        e = exp_vec(2, 2, 1, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL reset_two_steps: got %h expected %h", obs_a(), e);
        else pass_cnt++;
        #2 reset = 0;
        #1;
        e = exp_vec(0, 0, 0, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL reset_async_clear: got %h expected %h", obs_a(), e);
        else pass_cnt++;
        @(negedge clk_2) reset = 1;
        md_a = 0; mc_a = 0; md_b = 0; mc_b = 0;
        // Once reset is released, A stays idle until a new start arrives.
        @(posedge clk_2);
        #1;
        total_cnt++;
        if (obs_a() !== e) $display("FAIL reset_stays_idle: got %h expected %h", obs_a(), e);
        else pass_cnt++;
    endtask

    task automatic test_parallel(input logic [NBITS-1:0] val, input string name);
        vec_t e;
        @(negedge clk_2) begin bus_a.start = 1; bus_a.selecao = 1; bus_a.entradaParalela = val; end
        @(posedge clk_2);
        #1;
        e = exp_vec(md_a, mc_a, 1, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL %s_load: got %h expected %h", name, obs_a(), e);
        else pass_cnt++;
        @(negedge clk_2) begin bus_a.start = 0; bus_a.selecao = 1'($urandom); end
        @(posedge clk_2);
        #1;
        md_a = int'(val);
        e = exp_vec(md_a, mc_a, 1, 1);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL %s_done: got %h expected %h", name, obs_a(), e);
        else pass_cnt++;
        @(negedge clk_2) bus_a.entradaParalela = NBITS'($urandom);
        @(posedge clk_2);
        #1;
        e = exp_vec(md_a, mc_a, 0, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL %s_idle: got %h expected %h", name, obs_a(), e);
        else pass_cnt++;
    endtask

    // bits[NBITS-1] is shifted in first. 'noisy' toggles the inputs that are ignored during SHIFT.
    task automatic test_serial_a(input logic [NBITS-1:0] bits, input bit noisy, input string name);
        vec_t e;
        int b;
        logic [NBITS-1:0] got;
        exp_q.push_back(bits);
        @(negedge clk_2) begin
            bus_a.start = 1; bus_a.selecao = 0; bus_a.entradaSerial = 1'($urandom);
        end
        @(posedge clk_2);
        #1;
        mc_a = 0;
        e = exp_vec(md_a, 0, 1, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL %s_start: got %h expected %h", name, obs_a(), e);
        else pass_cnt++;
        for (int j = 0; j < NBITS; j++) begin
            @(negedge clk_2) begin
                b = int'(bits[NBITS-1-j]);
                bus_a.entradaSerial = 1'(b);
                if (noisy) begin
                    bus_a.start = 1'($urandom);
                    bus_a.selecao = 1'($urandom);
                    bus_a.entradaParalela = NBITS'(5);
                end else begin
                    bus_a.start = 0;
                end
            end
            @(posedge clk_2);
            #1;
            md_a = step_model(md_a, b);
            mc_a++;
            e = exp_vec(md_a, mc_a, 1, (j == NBITS - 1));
            total_cnt++;
            if (obs_a() !== e) $display("FAIL %s_step%0d: got %h expected %h", name, j + 1, obs_a(), e);
            else pass_cnt++;
        end
        @(negedge clk_2) begin bus_a.start = 0; bus_a.entradaSerial = 1'($urandom); end
        @(posedge clk_2);
        #1;
        e = exp_vec(md_a, mc_a, 0, 0);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL %s_idle: got %h expected %h", name, obs_a(), e);
        else pass_cnt++;
        got = exp_q.pop_front();
        total_cnt++;
        if (bus_a.dados !== got) $display("FAIL %s_final: got %h expected %h", name, bus_a.dados, got);
        else pass_cnt++;
    endtask

    task automatic test_held_start(input logic [NBITS-1:0] val);
        vec_t e;
        @(negedge clk_2) begin bus_a.start = 1; bus_a.selecao = 1; bus_a.entradaParalela = val; end
        @(posedge clk_2);
        @(posedge clk_2);
        #1;
        md_a = int'(val);
        e = exp_vec(md_a, mc_a, 1, 1);
        total_cnt++;
        if (obs_a() !== e) $display("FAIL held_done: got %h expected %h", obs_a(), e);
        else pass_cnt++;
        // start stays high: the bench sees no new operation and dados holds.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2) begin
                bus_a.selecao = 1'($urandom);
                bus_a.entradaParalela = ~val;
                bus_a.entradaSerial = 1'($urandom);
            end
            @(posedge clk_2);
            #1;
            e = exp_vec(md_a, mc_a, 0, 0);
            total_cnt++;
            if (obs_a() !== e) $display("FAIL held_hold%0d: got %h expected %h", i, obs_a(), e);
            else pass_cnt++;
        end
        @(negedge clk_2) bus_a.start = 0;
        @(posedge clk_2);
        #1;
        total_cnt++;
        if (obs_a() !== e) $display("FAIL held_release: got %h expected %h", obs_a(), e);
        else pass_cnt++;
        // Reasserting start must begin a fresh operation.
        test_parallel(~val, "held_retrigger");
    endtask

    // Serial run on the TICK_DIV=3 instance: shifts happen only every TD_B edges.
    task automatic test_tick_div(input bit all_ones, input string name);
        vec_t e;
        int b;
        logic [NBITS-1:0] bits, got;
        bits = all_ones ? '1 : NBITS'($urandom);
        exp_q.push_back(bits);
        @(negedge clk_2) begin
            bus_b.start = 1; bus_b.selecao = 0; bus_b.entradaSerial = all_ones ? 1'b1 : 1'($urandom);
        end
        @(posedge clk_2);
        #1;
        mc_b = 0;
        e = exp_vec(md_b, 0, 1, 0);
        total_cnt++;
        if (obs_b() !== e) $display("FAIL %s_start: got %h expected %h", name, obs_b(), e);
        else pass_cnt++;
        for (int i = 1; i <= TD_B * NBITS; i++) begin
            @(negedge clk_2) begin
                bus_b.start = 1'(i % 2);
                bus_b.selecao = 1'($urandom);
                bus_b.entradaParalela = NBITS'($urandom);
                if (i % TD_B == 0) b = int'(bits[NBITS - (i / TD_B)]);
                else b = all_ones ? 1 : int'($urandom_range(0, 1));
                bus_b.entradaSerial = 1'(b);
            end
            @(posedge clk_2);
            #1;
            if (i % TD_B == 0) begin
                md_b = step_model(md_b, b);
                mc_b++;
            end
            e = exp_vec(md_b, mc_b, 1, (i == TD_B * NBITS));
            total_cnt++;
            if (obs_b() !== e) $display("FAIL %s_cycle%0d: got %h expected %h", name, i, obs_b(), e);
            else pass_cnt++;
        end
        @(negedge clk_2) bus_b.start = 0;
        @(posedge clk_2);
        #1;
        e = exp_vec(md_b, mc_b, 0, 0);
        total_cnt++;
        if (obs_b() !== e) $display("FAIL %s_idle: got %h expected %h", name, obs_b(), e);
        else pass_cnt++;
        got = exp_q.pop_front();
        total_cnt++;
        if (bus_b.dados !== got) $display("FAIL %s_final: got %h expected %h", name, bus_b.dados, got);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 1) == 1)
                test_parallel(NBITS'($urandom), $sformatf("rnd%0d_par", n));
            else
                test_serial_a(NBITS'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d_ser", n));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_parallel(4'hA, "par_a");
        test_serial_a(4'b1011, 1'b0, "ser_1011");
        test_held_start(4'h6);
        test_tick_div(1'b1, "td3_ones");
        test_tick_div(1'b0, "td3_rand");
        test_serial_a(NBITS'($urandom), 1'b1, "ser_ignored");
        test_random();
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
